// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the pipeline control block: stage indices, FSM states, flush patterns.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pipe_pkg;

  // Bit positions of each pipeline register in pipe_we / pipe_flush
  localparam int STG_IFID  = 0;
  localparam int STG_IDEX  = 1;
  localparam int STG_EXMEM = 2;
  localparam int STG_MEMWB = 3;

  // Interrupt entry flushes IF-ID, ID-EX and EX-MEM; MEM-WB still commits
  localparam logic [3:0] FLUSH_ENTER = 4'b0111;
  // ERET squashes the two youngest stages behind it
  localparam logic [3:0] FLUSH_RET   = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTER  = 2'd1,
    ST_IN_ISR = 2'd2,
    ST_RETURN = 2'd3
  } ctrl_state_e;

  // Per-cycle control word handed to the pipeline registers and PC
  typedef struct packed {
    logic [3:0] we;
    logic [3:0] flush;
    logic       pc_we;
    logic       pc_redirect;
  } pipe_ctrl_t;

  // Handler vector address; 32-bit arithmetic, overflow wraps silently
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [31:0] idx,
                                           input logic [31:0] stride);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the interrupt request lines.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the consumer decides when to act on vld.
module irq_prio_enc #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  output logic          vld,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  // Scan from the top down so the lowest set bit is the last (winning) write
  always_comb begin
    idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

  assign vld    = |req;
  // Isolate the lowest set bit for the acknowledge vector
  assign onehot = req & ~(req - N'(1));

endmodule

// File: rtl/intr_pipe_ctrl.sv
// Pipeline control: write-enable/flush for IF-ID..MEM-WB and PC, plus interrupt entry and ERET return.
// Latency: hazard controls are combinational; interrupt entry takes effect the cycle after the request is accepted.
// Backpressure: stall_req holds the PC and IF-ID and defers interrupt entry and ERET until it drops.
// Optional build macro IRQ_MASK_EN adds an irq_mask input that gates individual request lines.
module intr_pipe_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned NUM_IRQ      = 4,
  parameter logic [31:0] HANDLER_BASE = 32'h0000_0040,
  parameter int unsigned VEC_STRIDE   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_req,
`ifdef IRQ_MASK_EN
  input  logic [NUM_IRQ-1:0] irq_mask,
`endif
  input  logic               stall_req,
  input  logic               branch_taken,
  input  logic               eret,
  input  logic [31:0]        ex_pc,
  output logic [3:0]         pipe_we,
  output logic [3:0]         pipe_flush,
  output logic               pc_we,
  output logic               pc_redirect,
  output logic [31:0]        pc_target,
  output logic [31:0]        sepc,
  output logic               int_active,
  output logic [NUM_IRQ-1:0] irq_ack
);

  localparam int unsigned IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  ctrl_state_e        state;
  logic [IDW-1:0]     irq_id;
  logic [31:0]        sepc_q;
  logic [NUM_IRQ-1:0] irq_eff;
  logic               enc_vld;
  logic [IDW-1:0]     enc_idx;
  logic [NUM_IRQ-1:0] enc_onehot;
  pipe_ctrl_t         ctl;
  logic [31:0]        tgt;

`ifdef IRQ_MASK_EN
  assign irq_eff = irq_req & ~irq_mask;
`else
  assign irq_eff = irq_req;
`endif

  irq_prio_enc #(
    .N  (NUM_IRQ),
    .IW (IDW)
  ) u_prio (
    .req    (irq_eff),
    .vld    (enc_vld),
    .idx    (enc_idx),
    .onehot (enc_onehot)
  );

  // Entry is only taken when the pipe is moving freely; hazards defer it a cycle
  logic take_irq;
  assign take_irq = enc_vld && !stall_req && !branch_taken;

  // FSM and registered outputs; reset discards any in-flight ISR or flush
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      sepc_q     <= '0;
      irq_id     <= '0;
      int_active <= 1'b0;
      irq_ack    <= '0;
    end else begin
      irq_ack <= '0;
      case (state)
        ST_IDLE: begin
          if (take_irq) begin
            state   <= ST_ENTER;
            sepc_q  <= ex_pc;
            irq_id  <= enc_idx;
            irq_ack <= enc_onehot;
          end
        end
        ST_ENTER: begin
          state      <= ST_IN_ISR;
          int_active <= 1'b1;
        end
        ST_IN_ISR: begin
          if (eret && !stall_req) state <= ST_RETURN;
        end
        ST_RETURN: begin
          state      <= ST_IDLE;
          int_active <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Combinational control decode from state and hazard inputs
  always_comb begin
    ctl = '{we: 4'hF, flush: 4'h0, pc_we: 1'b1, pc_redirect: 1'b0};
    tgt = '0;
    if (!rst) begin
      ctl.flush = 4'hF;
    end else begin
      case (state)
        ST_IDLE, ST_IN_ISR: begin
          // A taken branch squashes the stalled instruction anyway, so it wins
          if (branch_taken) begin
            ctl.flush[STG_IFID] = 1'b1;
            ctl.flush[STG_IDEX] = 1'b1;
          end else if (stall_req) begin
            ctl.pc_we          = 1'b0;
            ctl.we[STG_IFID]   = 1'b0;
            ctl.flush[STG_IDEX] = 1'b1;
          end
        end
        ST_ENTER: begin
          ctl.flush       = FLUSH_ENTER;
          ctl.pc_redirect = 1'b1;
          tgt             = vec_addr(HANDLER_BASE, 32'(irq_id), VEC_STRIDE);
        end
        ST_RETURN: begin
          ctl.flush       = FLUSH_RET;
          ctl.pc_redirect = 1'b1;
          tgt             = sepc_q;
        end
        default: ;
      endcase
    end
  end

  assign pipe_we     = ctl.we;
  assign pipe_flush  = ctl.flush;
  assign pc_we       = ctl.pc_we;
  assign pc_redirect = ctl.pc_redirect;
  assign pc_target   = tgt;
  assign sepc        = sepc_q;

endmodule

// File: tb/tb_intr_pipe_ctrl.sv
// Directed bench for intr_pipe_ctrl: reset, hazards, interrupt entry/return, priority, deferral.
// Latency: inputs applied after a clock edge, outputs sampled 1ns after the next edge.
// Backpressure: stall_req driven directly as a directed stimulus.
module tb_intr_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq_req;
`ifdef IRQ_MASK_EN
  logic [3:0]  irq_mask;
`endif
  logic        stall_req;
  logic        branch_taken;
  logic        eret;
  logic [31:0] ex_pc;
  logic [3:0]  pipe_we;
  logic [3:0]  pipe_flush;
  logic        pc_we;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic [31:0] sepc;
  logic        int_active;
  logic [3:0]  irq_ack;

  int checks = 0;
  int errors = 0;

  intr_pipe_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .irq_req      (irq_req),
`ifdef IRQ_MASK_EN
    .irq_mask     (irq_mask),
`endif
    .stall_req    (stall_req),
    .branch_taken (branch_taken),
    .eret         (eret),
    .ex_pc        (ex_pc),
    .pipe_we      (pipe_we),
    .pipe_flush   (pipe_flush),
    .pc_we        (pc_we),
    .pc_redirect  (pc_redirect),
    .pc_target    (pc_target),
    .sepc         (sepc),
    .int_active   (int_active),
    .irq_ack      (irq_ack)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; irq_req = '0; stall_req = 1'b0; branch_taken = 1'b0;
    eret = 1'b0; ex_pc = '0;
`ifdef IRQ_MASK_EN
    irq_mask = '0;
`endif
    // Reset held for two cycles
    step(); step();
    chk("rst_sepc",     32'(sepc),        32'h0);
    chk("rst_intact",   32'(int_active),  32'h0);
    chk("rst_flush",    32'(pipe_flush),  32'hF);
    chk("rst_we",       32'(pipe_we),     32'hF);
    chk("rst_pcwe",     32'(pc_we),       32'h1);
    chk("rst_redir",    32'(pc_redirect), 32'h0);
    chk("rst_ack",      32'(irq_ack),     32'h0);
    rst = 1'b1; #1;
    chk("rel_flush",    32'(pipe_flush),  32'h0);
    chk("rel_we",       32'(pipe_we),     32'hF);

    // Load-use stall alone, then with a taken branch
    stall_req = 1'b1; #1;
    chk("stall_pcwe",   32'(pc_we),       32'h0);
    chk("stall_we",     32'(pipe_we),     32'hE);
    chk("stall_flush",  32'(pipe_flush),  32'h2);
    branch_taken = 1'b1; #1;
    chk("br_pcwe",      32'(pc_we),       32'h1);
    chk("br_flush",     32'(pipe_flush),  32'h3);
    chk("br_we",        32'(pipe_we),     32'hF);
    stall_req = 1'b0; branch_taken = 1'b0;

    // Interrupt entry on line 2
    irq_req = 4'b0100; ex_pc = 32'h0000_1008;
    step();
    chk("ent_ack",      32'(irq_ack),     32'h4);
    chk("ent_tgt",      pc_target,        32'h48);
    chk("ent_flush",    32'(pipe_flush),  32'h7);
    chk("ent_redir",    32'(pc_redirect), 32'h1);
    chk("ent_sepc",     sepc,             32'h1008);
    chk("ent_intact",   32'(int_active),  32'h0);
    irq_req = '0; ex_pc = 32'h0000_3000;
    step();
    chk("isr_intact",   32'(int_active),  32'h1);
    chk("isr_ack",      32'(irq_ack),     32'h0);
    chk("isr_redir",    32'(pc_redirect), 32'h0);

    // No nesting inside the handler
    irq_req = 4'b0001;
    step();
    chk("nest_ack",     32'(irq_ack),     32'h0);
    chk("nest_redir",   32'(pc_redirect), 32'h0);
    chk("nest_sepc",    sepc,             32'h1008);
    irq_req = '0;

    // ERET held off by a stall
    eret = 1'b1; stall_req = 1'b1;
    step();
    chk("eretst_redir", 32'(pc_redirect), 32'h0);
    chk("eretst_pcwe",  32'(pc_we),       32'h0);
    stall_req = 1'b0;
    step();
    chk("ret_redir",    32'(pc_redirect), 32'h1);
    chk("ret_tgt",      pc_target,        32'h1008);
    chk("ret_flush",    32'(pipe_flush),  32'h3);
    eret = 1'b0;
    step();
    chk("post_intact",  32'(int_active),  32'h0);
    chk("post_redir",   32'(pc_redirect), 32'h0);
    chk("post_sepc",    sepc,             32'h1008);

    // ERET while idle does nothing
    eret = 1'b1;
    step();
    chk("ereti_redir",  32'(pc_redirect), 32'h0);
    chk("ereti_intact", 32'(int_active),  32'h0);
    eret = 1'b0;

    // Priority with deferral by stall and then by branch
    irq_req = 4'b1010; stall_req = 1'b1; ex_pc = 32'h0000_2000;
    step();
    chk("dst_ack",      32'(irq_ack),     32'h0);
    chk("dst_redir",    32'(pc_redirect), 32'h0);
    stall_req = 1'b0; branch_taken = 1'b1;
    step();
    chk("dbr_ack",      32'(irq_ack),     32'h0);
    chk("dbr_sepc",     sepc,             32'h1008);
    branch_taken = 1'b0;
    step();
    chk("pri_ack",      32'(irq_ack),     32'h2);
    chk("pri_tgt",      pc_target,        32'h44);
    chk("pri_sepc",     sepc,             32'h2000);
    irq_req = '0;
    step();
    chk("pri_intact",   32'(int_active),  32'h1);

    // Reset in the middle of a handler
    rst = 1'b0; #1;
    chk("mrst_flush",   32'(pipe_flush),  32'hF);
    chk("mrst_tgt",     pc_target,        32'h0);
    step();
    chk("mrst_intact",  32'(int_active),  32'h0);
    chk("mrst_sepc",    sepc,             32'h0);
    rst = 1'b1; #1;
    chk("mrst_rel",     32'(pipe_flush),  32'h0);
    // Back in IDLE: a fresh request on line 3 enters immediately
    irq_req = 4'b1000; ex_pc = 32'h0000_0abc;
    step();
    chk("re_ack",       32'(irq_ack),     32'h8);
    chk("re_tgt",       pc_target,        32'h4C);
    irq_req = '0;
    step();

`ifdef IRQ_MASK_EN
    // Masked line must not be taken
    rst = 1'b0; step(); rst = 1'b1;
    irq_mask = 4'b0001; irq_req = 4'b0001;
    step();
    chk("mask_ack",     32'(irq_ack),     32'h0);
    chk("mask_redir",   32'(pc_redirect), 32'h0);
    step();
    chk("mask_intact",  32'(int_active),  32'h0);
    irq_req = '0; irq_mask = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
